// File: rtl/alu_pkg.sv
// Shared constants and FSM state type for the ALU driver slice.
package alu_pkg;

  localparam int OPCODE_W  = 3;
  localparam int OVF_CNT_W = 8;
  localparam int LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/alu_driver_if.sv
// Command / ALU / response bundle of the ALU driver.
// master = the driver itself, slave = the surrounding environment.
interface alu_driver_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [WIDTH-1:0]    cmd_in0;
  logic [WIDTH-1:0]    cmd_in1;
  logic [OPCODE_W-1:0] cmd_opcode;

  logic [WIDTH-1:0]    alu_in0;
  logic [WIDTH-1:0]    alu_in1;
  logic [OPCODE_W-1:0] alu_opcode;
  logic [WIDTH-1:0]    alu_out;
  logic                alu_overflow;

  logic                rsp_valid;
  logic                rsp_ready;
  logic [WIDTH-1:0]    rsp_data;
  logic                rsp_overflow;
  logic [OPCODE_W-1:0] rsp_opcode;

  logic                busy;

  modport master (
    input  cmd_valid, cmd_in0, cmd_in1, cmd_opcode,
    input  alu_out, alu_overflow,
    input  rsp_ready,
    output cmd_ready,
    output alu_in0, alu_in1, alu_opcode,
    output rsp_valid, rsp_data, rsp_overflow, rsp_opcode,
    output busy
  );

  modport slave (
    output cmd_valid, cmd_in0, cmd_in1, cmd_opcode,
    output alu_out, alu_overflow,
    output rsp_ready,
    input  cmd_ready,
    input  alu_in0, alu_in1, alu_opcode,
    input  rsp_valid, rsp_data, rsp_overflow, rsp_opcode,
    input  busy
  );

endinterface

// File: rtl/alu_drv_lat_cnt.sv
// Latency down-counter: loads the ALU latency on accept, counts down while
// waiting, and flags done when the current cycle is the last one.
module alu_drv_lat_cnt
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [LAT_CNT_W-1:0] load_val,
  input  logic                 dec,
  output logic                 done
);

  logic [LAT_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = dec && (cnt_q == LAT_CNT_W'(1));

endmodule

// File: rtl/alu_driver.sv
// ALU driver: accepts one command, drives a fixed-latency ALU, and holds the
// result until consumed. Optional macro ALU_DRIVER_OVF_CNT_EN adds ovf_count.
module alu_driver
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_driver_if.master         bus
`ifdef ALU_DRIVER_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0] ovf_count
`endif
);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    alu_in0_q, alu_in0_d;
  logic [WIDTH-1:0]    alu_in1_q, alu_in1_d;
  logic [OPCODE_W-1:0] alu_opcode_q, alu_opcode_d;
  logic [WIDTH-1:0]    rsp_data_q, rsp_data_d;
  logic                rsp_overflow_q, rsp_overflow_d;
  logic [OPCODE_W-1:0] rsp_opcode_q, rsp_opcode_d;
  logic                accept;
  logic                rsp_fire;
  logic                lat_done;

  assign accept   = (state_q == ST_IDLE) && bus.cmd_valid;
  assign rsp_fire = (state_q == ST_RESP) && bus.rsp_ready;

  alu_drv_lat_cnt u_lat_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (LAT_CNT_W'(ALU_LAT)),
    .dec      (state_q == ST_WAIT),
    .done     (lat_done)
  );

  // ALU operands are only ever overwritten on accept, so they hold otherwise
  always_comb begin
    state_d        = state_q;
    alu_in0_d      = alu_in0_q;
    alu_in1_d      = alu_in1_q;
    alu_opcode_d   = alu_opcode_q;
    rsp_data_d     = rsp_data_q;
    rsp_overflow_d = rsp_overflow_q;
    rsp_opcode_d   = rsp_opcode_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          alu_in0_d    = bus.cmd_in0;
          alu_in1_d    = bus.cmd_in1;
          alu_opcode_d = bus.cmd_opcode;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_done) begin
          rsp_data_d     = bus.alu_out;
          rsp_overflow_d = bus.alu_overflow;
          rsp_opcode_d   = alu_opcode_q;
          state_d        = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_fire) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      alu_in0_q      <= '0;
      alu_in1_q      <= '0;
      alu_opcode_q   <= '0;
      rsp_data_q     <= '0;
      rsp_overflow_q <= 1'b0;
      rsp_opcode_q   <= '0;
    end else begin
      state_q        <= state_d;
      alu_in0_q      <= alu_in0_d;
      alu_in1_q      <= alu_in1_d;
      alu_opcode_q   <= alu_opcode_d;
      rsp_data_q     <= rsp_data_d;
      rsp_overflow_q <= rsp_overflow_d;
      rsp_opcode_q   <= rsp_opcode_d;
    end
  end

  // cmd_ready is masked by rst so nothing looks acceptable while held in reset
  assign bus.cmd_ready    = (state_q == ST_IDLE) && !rst;
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.rsp_valid    = (state_q == ST_RESP);
  assign bus.alu_in0      = alu_in0_q;
  assign bus.alu_in1      = alu_in1_q;
  assign bus.alu_opcode   = alu_opcode_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_overflow = rsp_overflow_q;
  assign bus.rsp_opcode   = rsp_opcode_q;

`ifdef ALU_DRIVER_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] ovf_count_q, ovf_count_d;

  always_comb begin
    ovf_count_d = ovf_count_q;
    if (rsp_fire && rsp_overflow_q && (ovf_count_q != '1)) begin
      ovf_count_d = ovf_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_count_q <= '0;
    end else begin
      ovf_count_q <= ovf_count_d;
    end
  end

  assign ovf_count = ovf_count_q;
`endif

endmodule

// File: tb/tb_alu_driver.sv
// Self-checking bench for alu_driver: directed reset/backpressure/sweep/reset
// cases plus randomized operations checked against an arithmetic ALU model.
module tb_alu_driver;
  import alu_pkg::*;

  localparam int WIDTH   = 16;
  localparam int ALU_LAT = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;
  int ovf_exp       = 0;

  alu_driver_if #(.WIDTH(WIDTH)) bus ();

`ifdef ALU_DRIVER_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] ovf_count;
`endif

  alu_driver #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ALU_DRIVER_OVF_CNT_EN
    ,
    .ovf_count (ovf_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: plain integer arithmetic, result in low bits, overflow on top.
  // 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 not in0, 6 in0*2, 7 pass in1.
  function automatic logic [WIDTH:0] ref_alu(input logic [2:0] op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    longint sa, sb, full, modv;
    logic   ovf;
    sa   = longint'(a);
    sb   = longint'(b);
    modv = longint'(1) << WIDTH;
    ovf  = 1'b0;
    case (op)
      3'd0: begin full = sa + sb; ovf = (full >= modv); end
      3'd1: begin full = sa - sb; ovf = (full < 0); end
      3'd2: full = sa & sb;
      3'd3: full = sa | sb;
      3'd4: full = sa ^ sb;
      3'd5: full = (modv - 1) - sa;
      3'd6: begin full = sa * 2; ovf = (full >= modv); end
      default: full = sb;
    endcase
    if (full < 0) full = full + modv;
    full = full % modv;
    return {ovf, full[WIDTH-1:0]};
  endfunction

  // ALU seen by the driver: result valid ALU_LAT cycles after its inputs change
  logic [WIDTH:0] alu_comb, alu_res;
  always_comb alu_comb = ref_alu(bus.alu_opcode, bus.alu_in0, bus.alu_in1);

  if (ALU_LAT == 1) begin : g_alu_comb
    assign alu_res = alu_comb;
  end else begin : g_alu_pipe
    logic [WIDTH:0] pipe [1:ALU_LAT-1];
    always @(posedge clk) begin
      pipe[1] <= alu_comb;
      for (int i = 2; i < ALU_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign alu_res = pipe[ALU_LAT-1];
  end

  assign bus.alu_out      = alu_res[WIDTH-1:0];
  assign bus.alu_overflow = alu_res[WIDTH];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full command/response transaction, entered and left at a falling edge in IDLE.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] op, input int stall);
    logic [WIDTH:0] exp;
    int unsigned    acc_cyc;
    exp = ref_alu(op, a, b);
    bus.cmd_in0    = a;
    bus.cmd_in1    = b;
    bus.cmd_opcode = op;
    bus.cmd_valid  = 1'b1;
    for (int i = 0; i < 50 && !bus.cmd_ready; i++) @(negedge clk);
    check("cmd_ready_wait", 32'(bus.cmd_ready), 32'd1);
    acc_cyc = cyc + 1;
    @(negedge clk);
    // operands change after accept and must not leak into the operation
    bus.cmd_valid  = 1'($urandom_range(0, 1));
    bus.cmd_in0    = WIDTH'($urandom);
    bus.cmd_in1    = WIDTH'($urandom);
    bus.cmd_opcode = 3'($urandom);
    check("wait_busy", 32'(bus.busy), 32'd1);
    check("wait_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    for (int i = 0; i < 50 && !bus.rsp_valid; i++) begin
      bus.rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    check("rsp_valid_wait", 32'(bus.rsp_valid), 32'd1);
    check("latency", cyc - acc_cyc, 32'(ALU_LAT));
    check("rsp_data", 32'(bus.rsp_data), 32'(exp[WIDTH-1:0]));
    check("rsp_overflow", 32'(bus.rsp_overflow), 32'(exp[WIDTH]));
    check("rsp_opcode", 32'(bus.rsp_opcode), 32'(op));
    check("alu_in0_hold", 32'(bus.alu_in0), 32'(a));
    for (int s = 0; s < stall; s++) begin
      bus.cmd_valid  = 1'b1;
      bus.cmd_in0    = WIDTH'($urandom);
      bus.cmd_opcode = 3'($urandom);
      @(negedge clk);
      check("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_rsp_data", 32'(bus.rsp_data), 32'(exp[WIDTH-1:0]));
      check("stall_cmd_ready", 32'(bus.cmd_ready), 32'd0);
      check("stall_alu_in0", 32'(bus.alu_in0), 32'(a));
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("post_busy", 32'(bus.busy), 32'd0);
`ifdef ALU_DRIVER_OVF_CNT_EN
    if (exp[WIDTH] && ovf_exp < 255) ovf_exp++;
    check("ovf_count", 32'(ovf_count), 32'(ovf_exp));
`endif
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int unsigned     acc[$];
    logic [WIDTH:0]  expq[$];
    logic [2:0]      opq[$];
    int              sent, got;
    logic [WIDTH:0]  e;
    logic [2:0]      eo;

    bus.cmd_valid  = 1'b0;
    bus.cmd_in0    = '0;
    bus.cmd_in1    = '0;
    bus.cmd_opcode = '0;
    bus.rsp_ready  = 1'b0;

    // Reset held for three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_alu_in0", 32'(bus.alu_in0), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    check("rst_alu_opcode", 32'(bus.alu_opcode), 32'd0);
    rst = 1'b0;
    #1;
    check("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);

    // Single add with five cycles of backpressure, then without
    run_op(16'd4, 16'd20, 3'd0, 5);
    run_op(16'd4, 16'd20, 3'd0, 0);

    // Opcode sweep, command valid and response ready held high
    sent = 0;
    got  = 0;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 200 && got < 8; c++) begin
      if (sent < 8) begin
        bus.cmd_valid  = 1'b1;
        bus.cmd_in0    = 16'd4;
        bus.cmd_in1    = 16'd20;
        bus.cmd_opcode = sent[2:0];
      end else begin
        bus.cmd_valid = 1'b0;
      end
      if (bus.rsp_valid) begin
        if (expq.size() == 0) begin
          check("sweep_extra_rsp", 32'(bus.rsp_valid), 32'd0);
        end else begin
          e  = expq.pop_front();
          eo = opq.pop_front();
          check("sweep_rsp_data", 32'(bus.rsp_data), 32'(e[WIDTH-1:0]));
          check("sweep_rsp_ovf", 32'(bus.rsp_overflow), 32'(e[WIDTH]));
          check("sweep_rsp_opcode", 32'(bus.rsp_opcode), 32'(eo));
          if (e[WIDTH] && ovf_exp < 255) ovf_exp++;
        end
        got++;
      end
      if (sent < 8 && bus.cmd_ready) begin
        acc.push_back(cyc + 1);
        expq.push_back(ref_alu(sent[2:0], 16'd4, 16'd20));
        opq.push_back(sent[2:0]);
        sent++;
      end
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    check("sweep_sent", 32'(sent), 32'd8);
    check("sweep_got", 32'(got), 32'd8);
    for (int i = 1; i < acc.size(); i++)
      check("sweep_spacing", acc[i] - acc[i-1], 32'(ALU_LAT + 2));
`ifdef ALU_DRIVER_OVF_CNT_EN
    check("sweep_ovf_count", 32'(ovf_count), 32'(ovf_exp));
`endif

    // Wrap-around add
    run_op(16'hFFFF, 16'd1, 3'd0, 0);

    // Randomized operations with random backpressure
    for (int n = 0; n < 20; n++)
      run_op(WIDTH'($urandom), WIDTH'($urandom), 3'($urandom_range(0, 7)),
             int'($urandom_range(0, 3)));

    // Reset while waiting on the ALU aborts the operation
    bus.cmd_in0    = 16'd7;
    bus.cmd_in1    = 16'd9;
    bus.cmd_opcode = 3'd0;
    bus.cmd_valid  = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    check("abort_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("abort_alu_in0", 32'(bus.alu_in0), 32'd0);
    @(negedge clk);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b0;
    ovf_exp = 0;
    #1;
    check("abort_rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
`ifdef ALU_DRIVER_OVF_CNT_EN
    check("abort_ovf_count", 32'(ovf_count), 32'd0);
    for (int n = 0; n < 300; n++) run_op(16'hFFFF, 16'd1, 3'd0, 0);
    check("ovf_saturate", 32'(ovf_count), 32'd255);
`endif

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/alu_driver.md
ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 SHALL have parameter WIDTH, default 16, operand/result width.
REQ-003 SHALL have parameter ALU_LAT, default 1, legal values 1..15: cycles from ALU input change to valid ALU output.
REQ-004 SHALL have these ports:
  clk  input  1  clock, rising edge
  rst  input  1  asynchronous active-high reset
  cmd_valid  input  1  command offered
  cmd_ready  output  1  command accepted when valid&ready
  cmd_in0, cmd_in1  input  WIDTH  operands
  cmd_opcode  input  3  ALU opcode
  alu_in0, alu_in1  output  WIDTH  registered ALU operands
  alu_opcode  output  3  registered ALU opcode
  alu_out  input  WIDTH  ALU result
  alu_overflow  input  1  ALU overflow flag
  rsp_valid  output  1  response available
  rsp_ready  input  1  response consumed when valid&ready
  rsp_data  output  WIDTH  captured result
  rsp_overflow  output  1  captured overflow
  rsp_opcode  output  3  opcode of the response
  busy  output  1  high in any state other than IDLE

Function
REQ-005 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-006 IDLE: cmd_ready=1; on cmd_valid load alu_in0/alu_in1/alu_opcode from cmd_*, load latency counter with ALU_LAT, go WAIT.
REQ-007 WAIT: cmd_ready=0; counter decrements each cycle; on the edge ALU_LAT cycles after the accept edge capture alu_out, alu_overflow, alu_opcode into rsp_*, go RESP.
REQ-008 RESP: rsp_valid=1; rsp_* SHALL be stable until rsp_valid&rsp_ready; on handshake go IDLE.
REQ-009 Accept-to-rsp_valid latency SHALL be exactly ALU_LAT cycles; back-to-back accept spacing with rsp_ready held high SHALL be ALU_LAT+2 cycles.
REQ-010 alu_in0/alu_in1/alu_opcode SHALL hold their last values outside an accept edge; they SHALL NOT return to zero.
REQ-011 Only one operation SHALL be outstanding; cmd_valid while not in IDLE SHALL be ignored (not accepted, no side effect).
REQ-012 cmd_* SHALL be sampled only on the accept edge; changes afterwards SHALL NOT affect the operation.
REQ-013 rsp_ready while rsp_valid=0 SHALL have no effect.

Reset
REQ-014 While rst=1: state IDLE, cmd_ready=0, rsp_valid=0, busy=0, alu_in0/alu_in1/rsp_data=0, alu_opcode/rsp_opcode=0, rsp_overflow=0, counter=0.
REQ-015 cmd_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-016 rst asserted in WAIT or RESP SHALL abort the operation; its response SHALL never be presented.

Configuration
REQ-017 With macro ALU_DRIVER_OVF_CNT_EN defined, SHALL add output ovf_count (8 bits), reset 0, incremented on each response handshake with rsp_overflow=1, saturating at 255.
REQ-018 Without ALU_DRIVER_OVF_CNT_EN, ovf_count and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-019 Shared package alu_pkg SHALL hold the opcode width constant (3), the FSM state typedef, and the overflow-counter width constant (8).
REQ-020 The latency counter SHALL be one sub-module alu_drv_lat_cnt (load, decrement, done at terminal count).

Verification (bench ALU model: registered, latency ALU_LAT, opcode 0 = add)
REQ-021 Reset: rst=1 for 3 cycles -> cmd_ready=0, rsp_valid=0, alu_in0=0, busy=0; first cycle after release cmd_ready=1.
REQ-022 Single op, ALU_LAT=1: in0=4, in1=20, opcode=0 -> rsp_valid 1 cycle after accept, rsp_data=24, rsp_overflow=0, rsp_opcode=0.
REQ-023 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid=1, rsp_data=24 stable, cmd_ready=0, a cmd_valid=1 offered meanwhile is not accepted.
REQ-024 Sweep: in0=4, in1=20, opcode 0..7 back-to-back, rsp_ready=1 -> 8 responses in order, rsp_opcode 0..7, accept spacing ALU_LAT+2 cycles.
REQ-025 Overflow: in0=16'hFFFF, in1=1, opcode=0 -> rsp_data=0, rsp_overflow=1; with ALU_DRIVER_OVF_CNT_EN, ovf_count=1, and 300 such ops -> ovf_count=255.
REQ-026 Reset mid-op: rst asserted during WAIT -> no rsp_valid for that op; cmd_ready=1 the cycle after release.
